// File: rtl/ebike_sensor_pkg.sv
// Shared e-bike sensor types and constants.
// The assist-current logic downstream imports this package too.
package ebike_sensor_pkg;

  localparam int TORQUE_W = 12;
  localparam int CAD_W    = 5;

  typedef logic [TORQUE_W-1:0] torque_t;
  typedef logic [CAD_W-1:0]    cad_t;

  localparam cad_t CAD_MAX = 5'd31;

  // Add one edge to a cadence count, holding at CAD_MAX.
  function automatic cad_t cad_sat_add(input cad_t cnt, input logic inc);
    cad_t res;
    res = cnt;
    if (inc && (cnt != CAD_MAX)) begin
      res = cnt + cad_t'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/cad_sync_edge.sv
// Two-flop synchronizer for the raw cadence pulse, plus a history flop
// that turns the synchronized level into a one-cycle rising-edge strobe.
module cad_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d_async,
  output logic rise
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d_async;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/pedal_sensor_cond.sv
// Pedal sensor conditioner: windowed cadence count, stall detection and
// a per-stroke exponential average of the torque sensor.
module pedal_sensor_cond
  import ebike_sensor_pkg::*;
#(
  parameter int CAD_WIN_W  = 22,
  parameter int NP_TIMEOUT = 25_000_000,
  parameter int AVG_SH     = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cadence_raw,
  input  logic [TORQUE_W-1:0] torque,
  output logic [TORQUE_W-1:0] avg_torque,
  output logic [CAD_W-1:0]    cadence,
  output logic                not_pedaling,
  output logic                cad_upd
);

  localparam int IDLE_W = $clog2(NP_TIMEOUT + 1);
  localparam int ACC_W  = TORQUE_W + AVG_SH;

  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(NP_TIMEOUT);

  logic                 cad_rise;

  logic [CAD_WIN_W-1:0] win_q, win_d;
  logic                 win_term;
  cad_t                 cnt_q, cnt_d;
  cad_t                 cnt_inc;
  cad_t                 cadence_q, cadence_d;
  logic                 cad_upd_q, cad_upd_d;

  logic [IDLE_W-1:0]    idle_q, idle_d;
  logic                 np_q, np_d;

  torque_t              torque_q;
  logic [ACC_W-1:0]     acc_q, acc_d;
  torque_t              avg_q, avg_d;

  cad_sync_edge u_sync (
    .clk     (clk),
    .rst     (rst),
    .d_async (cadence_raw),
    .rise    (cad_rise)
  );

  // Window: an edge landing on the terminal cycle belongs to the ending window.
  always_comb begin
    win_d     = win_q + CAD_WIN_W'(1);
    win_term  = &win_q;
    cnt_inc   = cad_sat_add(cnt_q, cad_rise);
    cnt_d     = cnt_inc;
    cadence_d = cadence_q;
    cad_upd_d = 1'b0;
    if (win_term) begin
      cadence_d = cnt_inc;
      cnt_d     = '0;
      cad_upd_d = 1'b1;
    end
  end

  // Stall detect: comparing the next idle value makes not_pedaling rise
  // exactly NP_TIMEOUT cycles after the last edge; an edge always wins.
  always_comb begin
    idle_d = idle_q;
    np_d   = np_q;
    if (cad_rise) begin
      idle_d = '0;
      np_d   = 1'b0;
    end else begin
      if (idle_q != IDLE_MAX) begin
        idle_d = idle_q + IDLE_W'(1);
      end
      if (idle_d == IDLE_MAX) begin
        np_d = 1'b1;
      end
    end
  end

  // Accumulator holds avg << AVG_SH; the first stroke after a stall seeds it.
  always_comb begin
    acc_d = acc_q;
    if (cad_rise) begin
      if (np_q) begin
        acc_d = {torque_q, {AVG_SH{1'b0}}};
      end else begin
        acc_d = acc_q - (acc_q >> AVG_SH) + ACC_W'(torque_q);
      end
    end
    avg_d = acc_d[ACC_W-1:AVG_SH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q     <= '0;
      cnt_q     <= '0;
      cadence_q <= '0;
      cad_upd_q <= 1'b0;
      idle_q    <= '0;
      np_q      <= 1'b1;
      torque_q  <= '0;
      acc_q     <= '0;
      avg_q     <= '0;
    end else begin
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      cadence_q <= cadence_d;
      cad_upd_q <= cad_upd_d;
      idle_q    <= idle_d;
      np_q      <= np_d;
      torque_q  <= torque;
      acc_q     <= acc_d;
      avg_q     <= avg_d;
    end
  end

  assign avg_torque   = avg_q;
  assign cadence      = cadence_q;
  assign not_pedaling = np_q;
  assign cad_upd      = cad_upd_q;

endmodule

// File: tb/tb_pedal_sensor_cond.sv
// Directed bench for pedal_sensor_cond with an 8-bit cadence window,
// 600-cycle stall timeout and 1/4 averaging weight.
module tb_pedal_sensor_cond;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cadence_raw = 1'b0;
  logic [11:0] torque = 12'h000;
  logic [11:0] avg_torque;
  logic [4:0]  cadence;
  logic        not_pedaling;
  logic        cad_upd;

  int total = 0;
  int bad   = 0;

  pedal_sensor_cond #(
    .CAD_WIN_W  (8),
    .NP_TIMEOUT (600),
    .AVG_SH     (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cadence_raw  (cadence_raw),
    .torque       (torque),
    .avg_torque   (avg_torque),
    .cadence      (cadence),
    .not_pedaling (not_pedaling),
    .cad_upd      (cad_upd)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      $display("check %s: observed=%0h expected=%0h", tag, obs, exp);
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle raw pulse; its cad_rise is sampled on the third edge, so
  // after this task the effects of that stroke are visible.
  task automatic stroke();
    cadence_raw = 1'b1;
    step();
    cadence_raw = 1'b0;
    steps(2);
  endtask

  int n_upd;
  int n_wait;

  initial begin
    // Reset with the raw input toggling
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cadence_raw = ~cadence_raw;
      step();
    end
    rst = 1'b0;
    cadence_raw = 1'b0;
    chk("rst_avg", 32'(avg_torque), 32'h0);
    chk("rst_cad", 32'(cadence), 32'h0);
    chk("rst_np", 32'(not_pedaling), 32'h1);
    chk("rst_upd", 32'(cad_upd), 32'h0);

    // First stroke after idle seeds the average
    torque = 12'h400;
    steps(3);
    cadence_raw = 1'b1;
    step();
    cadence_raw = 1'b0;
    step();
    chk("seed_np_before", 32'(not_pedaling), 32'h1);
    chk("seed_avg_before", 32'(avg_torque), 32'h0);
    step();
    chk("seed_avg", 32'(avg_torque), 32'h400);
    chk("seed_np_after", 32'(not_pedaling), 32'h0);

    // Further strokes at 0x800: avg += (0x800 - avg) / 4, truncated
    torque = 12'h800;
    steps(3);
    chk("avg_hold", 32'(avg_torque), 32'h400);
    stroke();
    chk("avg_1", 32'(avg_torque), 32'h500);
    steps(5);
    stroke();
    chk("avg_2", 32'(avg_torque), 32'h5C0);
    steps(5);
    stroke();
    chk("avg_3", 32'(avg_torque), 32'h650);

    // Stall timeout counted from the last cad_rise
    steps(599);
    chk("to_599", 32'(not_pedaling), 32'h0);
    step();
    chk("to_600", 32'(not_pedaling), 32'h1);
    chk("to_avg_hold", 32'(avg_torque), 32'h650);

    // Stroke after stall reseeds; then an edge at 599 keeps it low
    stroke();
    chk("reseed_avg", 32'(avg_torque), 32'h800);
    chk("reseed_np", 32'(not_pedaling), 32'h0);
    steps(596);
    stroke();
    chk("edge599_np", 32'(not_pedaling), 32'h0);

    // cad_rise on the very cycle the idle timer would reach 600
    steps(597);
    cadence_raw = 1'b1;
    step();
    cadence_raw = 1'b0;
    step();
    chk("tie_599_np", 32'(not_pedaling), 32'h0);
    step();
    chk("tie_600_np", 32'(not_pedaling), 32'h0);
    steps(5);
    chk("tie_after_np", 32'(not_pedaling), 32'h0);

    // One edge per 32 cycles: 8 per window once fully in the pattern
    n_upd = 0;
    for (int i = 0; i < 1000; i++) begin
      cadence_raw = ((i % 32) == 0);
      step();
      if (cad_upd) begin
        n_upd++;
        if (n_upd > 1) chk("cad8", 32'(cadence), 32'd8);
      end
    end
    chk("cad8_updates", 32'(n_upd >= 3), 32'h1);

    // Reset during an active window
    rst = 1'b1;
    cadence_raw = 1'b0;
    step();
    rst = 1'b0;
    chk("mid_rst_cad", 32'(cadence), 32'h0);
    chk("mid_rst_np", 32'(not_pedaling), 32'h1);
    chk("mid_rst_upd", 32'(cad_upd), 32'h0);
    chk("mid_rst_avg", 32'(avg_torque), 32'h0);
    n_wait = 0;
    while (!cad_upd && n_wait < 400) begin
      step();
      n_wait++;
    end
    chk("mid_rst_first_upd", 32'(n_wait), 32'd256);

    // One edge per 4 cycles saturates at 31
    n_upd = 0;
    for (int i = 0; i < 700; i++) begin
      cadence_raw = ((i % 4) < 2);
      step();
      if (cad_upd) begin
        n_upd++;
        if (n_upd > 1) chk("cad_sat", 32'(cadence), 32'd31);
      end
    end
    chk("cad_sat_updates", 32'(n_upd >= 2), 32'h1);
    cadence_raw = 1'b0;

    // Edge on the terminal cycle counts in the ending window; the next
    // edge, two cycles later, counts in the following one.
    rst = 1'b1;
    step();
    rst = 1'b0;
    steps(253);
    cadence_raw = 1'b1;
    step();
    cadence_raw = 1'b0;
    step();
    cadence_raw = 1'b1;
    step();
    cadence_raw = 1'b0;
    chk("term_upd", 32'(cad_upd), 32'h1);
    chk("term_cad", 32'(cadence), 32'd1);
    step();
    chk("term_upd_pulse", 32'(cad_upd), 32'h0);
    chk("term_cad_hold", 32'(cadence), 32'd1);
    steps(255);
    chk("next_upd", 32'(cad_upd), 32'h1);
    chk("next_cad", 32'(cadence), 32'd1);
    steps(256);
    chk("empty_cad", 32'(cadence), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
